// File: rtl/sme_driver.sv
// Driver that loads string/pattern buffers and streams them to a matching
// engine, then captures the engine result or a timeout.
module sme_driver #(
  parameter int STR_MAX = 32,
  parameter int PAT_MAX = 8,
  parameter int TO_CYC  = 200
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ld_en,
  input  logic       ld_sel,
  input  logic [7:0] ld_data,
  input  logic       ld_clr,
  input  logic       start,
  input  logic       new_str,
  output logic       busy,
  output logic [7:0] chardata,
  output logic       isstring,
  output logic       ispattern,
  input  logic       valid,
  input  logic       match,
  input  logic [4:0] match_index,
  output logic       done,
  output logic       res_match,
  output logic [4:0] res_index,
  output logic       timeout
);

  localparam int MAXD = (STR_MAX > PAT_MAX) ? STR_MAX : PAT_MAX;
  localparam int LW = $clog2(MAXD + 1);
  localparam int SW = $clog2(STR_MAX);
  localparam int PW = $clog2(PAT_MAX);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] SEND_S = 3'd1;
  localparam logic [2:0] GAP    = 3'd2;
  localparam logic [2:0] SEND_P = 3'd3;
  localparam logic [2:0] WAIT   = 3'd4;
  localparam logic [2:0] DONE   = 3'd5;

  logic [7:0]    str_mem [STR_MAX];
  logic [7:0]    pat_mem [PAT_MAX];
  logic [LW-1:0] str_len, pat_len;
  logic [LW-1:0] k, k_nxt;
  logic [2:0]    state, state_nxt;
  logic [7:0]    cnt, cnt_nxt;
  logic [7:0]    char_nxt;
  logic          accept, got, expired;
  logic          str_wr, pat_wr;

  assign str_wr = ld_en && !busy && !ld_clr && !ld_sel
                  && (str_len != LW'(STR_MAX));
  assign pat_wr = ld_en && !busy && !ld_clr && ld_sel
                  && (pat_len != LW'(PAT_MAX));

  always_comb begin
    state_nxt = state;
    k_nxt     = k;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    got       = 1'b0;
    expired   = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (new_str && str_len != '0 && pat_len != '0) begin
            state_nxt = SEND_S;
            accept    = 1'b1;
            k_nxt     = '0;
          end else if (!new_str && pat_len != '0) begin
            state_nxt = SEND_P;
            accept    = 1'b1;
            k_nxt     = '0;
          end
        end
      end
      SEND_S: begin
        if (k == str_len - 1'b1) begin
          state_nxt = GAP;
          k_nxt     = '0;
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      GAP: begin
        state_nxt = SEND_P;
        k_nxt     = '0;
      end
      SEND_P: begin
        if (k == pat_len - 1'b1) begin
          state_nxt = WAIT;
          k_nxt     = '0;
          cnt_nxt   = '0;
        end else begin
          k_nxt = k + 1'b1;
        end
      end
      WAIT: begin
        // valid has priority over the timeout limit
        if (valid) begin
          got       = 1'b1;
          state_nxt = DONE;
        end else if (cnt == 8'(TO_CYC - 1)) begin
          expired   = 1'b1;
          state_nxt = DONE;
        end else begin
          cnt_nxt = cnt + 8'd1;
        end
      end
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    char_nxt = 8'd0;
    if (state_nxt == SEND_S)
      char_nxt = str_mem[k_nxt[SW-1:0]];
    else if (state_nxt == SEND_P)
      char_nxt = pat_mem[k_nxt[PW-1:0]];
  end

  always_ff @(posedge clk) begin
    if (str_wr) str_mem[str_len[SW-1:0]] <= ld_data;
    if (pat_wr) pat_mem[pat_len[PW-1:0]] <= ld_data;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state     <= IDLE;
      k         <= '0;
      cnt       <= '0;
      str_len   <= '0;
      pat_len   <= '0;
      busy      <= 1'b0;
      isstring  <= 1'b0;
      ispattern <= 1'b0;
      chardata  <= 8'd0;
      done      <= 1'b0;
      res_match <= 1'b0;
      res_index <= 5'd0;
      timeout   <= 1'b0;
    end else begin
      state     <= state_nxt;
      k         <= k_nxt;
      cnt       <= cnt_nxt;
      busy      <= (state_nxt != IDLE);
      isstring  <= (state_nxt == SEND_S);
      ispattern <= (state_nxt == SEND_P);
      chardata  <= char_nxt;
      done      <= (state_nxt == DONE);
      // lengths are frozen while busy so a running stream stays coherent
      if (!busy && ld_clr) begin
        str_len <= '0;
        pat_len <= '0;
      end else begin
        if (str_wr) str_len <= str_len + 1'b1;
        if (pat_wr) pat_len <= pat_len + 1'b1;
      end
      if (accept) begin
        res_match <= 1'b0;
        res_index <= 5'd0;
        timeout   <= 1'b0;
      end else if (got) begin
        res_match <= match;
        res_index <= match_index;
        timeout   <= 1'b0;
      end else if (expired) begin
        res_match <= 1'b0;
        res_index <= 5'd0;
        timeout   <= 1'b1;
      end
    end
  end

endmodule
